// File: rtl/stage_one.sv
// stage_one: first stage of the function-evaluation datapath.
// Captures two IEEE-754 single operands per job. For each operand it produces
// a signed Q2.20 fixed-point value, the operand halved, and the operand squared.
// A job takes four enabled cycles: IDLE (accept), CAPTURE, COMPUTE, OUTPUT.
// done is high during the OUTPUT cycle.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   clk_en                global enable; every register holds while low
//   start                 job request, honoured only in IDLE
//   x_one, x_two          float operands, captured on an accepted start
//   done                  completion pulse, high in the OUTPUT cycle
//   out_one/_two          operand as signed Q2.20, saturating at |x| >= 2
//   half_out_one/_two     operand * 0.5
//   square_out_one/_two   operand * operand
//
// Build option: define STAGE1_SQUARE_RNE_EN to round squares to nearest-even.
// When it is undefined, squares truncate toward zero.
module stage_one #(
  parameter int unsigned FLT_DATA_WIDTH    = 32,
  parameter int unsigned CORDIC_DATA_WIDTH = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [FLT_DATA_WIDTH-1:0]    x_one,
  input  logic [FLT_DATA_WIDTH-1:0]    x_two,
  output logic                         done,
  output logic [CORDIC_DATA_WIDTH-1:0] out_one,
  output logic [CORDIC_DATA_WIDTH-1:0] out_two,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_two,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_two
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  // Rounding needs the whole 48-bit mantissa product. Truncation only needs
  // bits [47:23], so the product register is trimmed to those bits.
`ifdef STAGE1_SQUARE_RNE_EN
  localparam int unsigned PROD_W = 48;
`else
  localparam int unsigned PROD_W = 25;
`endif
  localparam int unsigned PROD_LSB = 48 - PROD_W;

  logic [1:0]        state_q, state_d;
  logic              load_c, prod_en_c, res_en_c;
  logic [31:0]       op_one, op_two;
  logic [PROD_W-1:0] prod_one, prod_two;

  // Square of the 24-bit significand, keeping only the bits used downstream.
  function automatic logic [PROD_W-1:0] mant_sq(input logic [22:0] m);
    return PROD_W'((48'({1'b1, m}) * 48'({1'b1, m})) >> PROD_LSB);
  endfunction

  // Normalise and round the significand square into a float. The sign is always +.
  function automatic logic [31:0] square_fn(input logic [30:0] x, input logic [PROD_W-1:0] p);
    logic [7:0]  e;
    logic [9:0]  t;      // biased result exponent + 127, kept unsigned
    logic [22:0] mant;
    logic        up;
    logic [23:0] mr;
    logic [31:0] r;
    e    = x[30:23];
    t    = '0;
    mant = '0;
    up   = 1'b0;
    mr   = '0;
    r    = '0;
    if (e == 8'hFF) begin
      r = (x[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    end else if (e != 8'd0) begin
      t    = {1'b0, e, 1'b0} + 10'(p[PROD_W-1]);
      mant = p[PROD_W-1] ? p[PROD_W-2 -: 23] : p[PROD_W-3 -: 23];
`ifdef STAGE1_SQUARE_RNE_EN
      up   = p[47] ? (p[23] & ((|p[22:0]) | mant[0]))
                   : (p[22] & ((|p[21:0]) | mant[0]));
`endif
      mr   = {1'b0, mant} + 24'(up);
      // Rounding carry out of the fraction renormalises to 1.0 * 2^(e+1).
      if (mr[23]) t = t + 10'd1;
      if (t <= 10'd127)      r = 32'h0000_0000;
      else if (t >= 10'd382) r = 32'h7F80_0000;
      else                   r = {1'b0, 8'(t - 10'd127), mr[22:0]};
    end
    return r;
  endfunction

  // Halve by decrementing the exponent. Exponent 1, zero and denormals become signed zero.
  function automatic logic [31:0] half_fn(input logic [31:0] x);
    logic [31:0] r;
    if (x[30:23] == 8'hFF)      r = x;
    else if (x[30:23] <= 8'd1)  r = {x[31], 31'd0};
    else                        r = {x[31], x[30:23] - 8'd1, x[22:0]};
    return r;
  endfunction

  // Convert to Q2.20, truncating toward zero and saturating at |x| >= 2.
  function automatic logic [21:0] fixed_fn(input logic [31:0] x);
    logic [7:0]  e;
    logic [23:0] mag;
    logic [21:0] sat;
    logic [21:0] r;
    e   = x[30:23];
    sat = x[31] ? 22'h20_0000 : 22'h1F_FFFF;
    mag = '0;
    r   = '0;
    if (e == 8'hFF) begin
      r = (x[22:0] != 23'd0) ? 22'd0 : sat;
    end else if (e >= 8'd128) begin
      r = sat;
    end else if (e != 8'd0) begin
      // value * 2^20 = significand * 2^(e-130); e <= 127 gives a shift of at least 3
      mag = {1'b1, x[22:0]} >> (8'd130 - e);
      r   = 22'(mag);
      if (x[31]) r = -r;
    end
    return r;
  endfunction

  // Next-state and stage enables.
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    prod_en_c = 1'b0;
    res_en_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAPTURE;
          load_c  = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d   = S_COMPUTE;
        prod_en_c = 1'b1;
      end
      S_COMPUTE: begin
        state_d  = S_OUTPUT;
        res_en_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and done. done follows the OUTPUT state, so it holds while frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      done    <= (state_d == S_OUTPUT);
    end
  end

  // Operand capture, product formation and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_one         <= '0;
      op_two         <= '0;
      prod_one       <= '0;
      prod_two       <= '0;
      out_one        <= '0;
      out_two        <= '0;
      half_out_one   <= '0;
      half_out_two   <= '0;
      square_out_one <= '0;
      square_out_two <= '0;
    end else if (clk_en) begin
      if (load_c) begin
        op_one <= 32'(x_one);
        op_two <= 32'(x_two);
      end
      if (prod_en_c) begin
        prod_one <= mant_sq(op_one[22:0]);
        prod_two <= mant_sq(op_two[22:0]);
      end
      if (res_en_c) begin
        square_out_one <= FLT_DATA_WIDTH'(square_fn(op_one[30:0], prod_one));
        square_out_two <= FLT_DATA_WIDTH'(square_fn(op_two[30:0], prod_two));
        half_out_one   <= FLT_DATA_WIDTH'(half_fn(op_one));
        half_out_two   <= FLT_DATA_WIDTH'(half_fn(op_two));
        out_one        <= CORDIC_DATA_WIDTH'(fixed_fn(op_one));
        out_two        <= CORDIC_DATA_WIDTH'(fixed_fn(op_two));
      end
    end
  end

endmodule

// File: tb/tb_stage_one.sv
// Testbench for stage_one: directed spec vectors plus randomized jobs checked
// against a real-arithmetic reference model.
module tb_stage_one;

`ifdef STAGE1_SQUARE_RNE_EN
  localparam bit RNE = 1'b1;
  localparam logic [31:0] SQ_EDGE = 32'h3F80_1003;
`else
  localparam bit RNE = 1'b0;
  localparam logic [31:0] SQ_EDGE = 32'h3F80_1002;
`endif

  logic        clk, rst, clk_en, start;
  logic [31:0] x_one, x_two;
  logic        done;
  logic [21:0] out_one, out_two;
  logic [31:0] half_out_one, half_out_two, square_out_one, square_out_two;

  int checks = 0;
  int errors = 0;

  string names [6] = '{"square_one", "square_two", "half_one", "half_two", "fixed_one", "fixed_two"};

  // Each row: x_one, x_two, sq1, sq2, half1, half2, fixed1, fixed2
  logic [31:0] dir_tab [4][8] = '{
    '{32'h4040_0000, 32'hBF00_0000, 32'h4110_0000, 32'h3E80_0000, 32'h3FC0_0000, 32'hBE80_0000, 32'h001F_FFFF, 32'h0038_0000},
    '{32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3F00_0000, 32'h0000_0000, 32'h0010_0000, 32'h0000_0000},
    '{32'h3F80_0801, 32'h7F00_0000, SQ_EDGE,       32'h7F80_0000, 32'h3F00_0801, 32'h7E80_0000, 32'h0010_0100, 32'h001F_FFFF},
    '{32'h0080_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h0000_0000}
  };

  stage_one dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .start          (start),
    .x_one          (x_one),
    .x_two          (x_two),
    .done           (done),
    .out_one        (out_one),
    .out_two        (out_two),
    .half_out_one   (half_out_one),
    .half_out_two   (half_out_two),
    .square_out_one (square_out_one),
    .square_out_two (square_out_two)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Pack an exactly-representable-in-double value into single precision.
  function automatic logic [31:0] r2f(input real v, input bit rne);
    logic [63:0] d;
    int          e;
    logic [22:0] m;
    logic [23:0] mr;
    bit          up;
    d = $realtobits(v);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e  = int'(d[62:52]) - 896;
    m  = d[51:29];
    up = rne && d[28] && ((d[27:0] != 28'd0) || m[0]);
    mr = {1'b0, m} + 24'(up);
    if (mr[23]) e = e + 1;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], mr[22:0]};
  endfunction

  function automatic void model(input logic [31:0] x, output logic [31:0] sq,
                                output logic [31:0] hf, output logic [21:0] fx);
    real v;
    if (x[30:23] == 8'hFF) begin
      hf = x;
      if (x[22:0] != 23'd0) begin sq = 32'h7FC0_0000; fx = 22'd0; end
      else begin sq = 32'h7F80_0000; fx = x[31] ? 22'h20_0000 : 22'h1F_FFFF; end
    end else if (x[30:23] == 8'd0) begin
      sq = 32'd0; hf = {x[31], 31'd0}; fx = 22'd0;
    end else begin
      v  = f2r(x);
      sq = r2f(v * v, RNE);
      hf = r2f(v / 2.0, 1'b0);
      if (v >= 2.0)       fx = 22'h1F_FFFF;
      else if (v <= -2.0) fx = 22'h20_0000;
      else                fx = 22'($rtoi(v * 1048576.0));
    end
  endfunction

  function automatic logic [5:0][31:0] expect_pair(input logic [31:0] a, input logic [31:0] b);
    logic [5:0][31:0] r;
    logic [31:0] sq, hf;
    logic [21:0] fx;
    model(a, sq, hf, fx); r[0] = sq; r[2] = hf; r[4] = 32'(fx);
    model(b, sq, hf, fx); r[1] = sq; r[3] = hf; r[5] = 32'(fx);
    return r;
  endfunction

  function automatic logic [5:0][31:0] observe();
    logic [5:0][31:0] r;
    r[0] = square_out_one; r[1] = square_out_two;
    r[2] = half_out_one;   r[3] = half_out_two;
    r[4] = 32'(out_one);   r[5] = 32'(out_two);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       e = r[30:23];
      1:       e = 8'($urandom_range(120, 135));
      2:       e = 8'd0;
      3:       e = 8'hFF;
      4:       e = 8'($urandom_range(1, 3));
      5:       e = 8'($urandom_range(188, 194));
      6:       e = 8'($urandom_range(60, 66));
      default: e = 8'($urandom_range(125, 128));
    endcase
    r[30:23] = e;
    if ($urandom_range(0, 3) == 0) r[22:0] = (e == 8'hFF) ? 23'd0 : 23'h7F_FFFF;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    x_one  = a;
    x_two  = b;
    start  = 1'b1;
    clk_en = 1'b1;
    tick();
    start = 1'b0;
    x_one = $urandom;
    x_two = $urandom;
  endtask

  // lat = cycle index (accept cycle = 0) in which done is observed; 16 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0][31:0] got;
    #2;
    got = observe();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== 32'd0) begin errors++; $display("FAIL reset %s: got %h expected 0", names[i], got[i]); end
    end
    start = 1'b1; clk_en = 1'b1;
    repeat (4) tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_hold done: got %b expected 0", done); end
    start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [5:0][31:0] got;
    int lat;
    for (int r = 0; r < 4; r++) begin
      launch(dir_tab[r][0], dir_tab[r][1]);
      wait_done(lat);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL directed[%0d] latency: got %0d expected 3", r, lat); end
      got = observe();
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== dir_tab[r][i+2]) begin
          errors++;
          $display("FAIL directed[%0d] %s: got %h expected %h", r, names[i], got[i], dir_tab[r][i+2]);
        end
      end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL directed[%0d] done_pulse: got %b expected 0", r, done); end
    end
  endtask

  task automatic test_random();
    logic [5:0][31:0] got, exp;
    logic [31:0] a, b;
    int lat;
    for (int n = 0; n < 60; n++) begin
      a = rand_op();
      b = rand_op();
      exp = expect_pair(a, b);
      launch(a, b);
      wait_done(lat);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL random[%0d] latency: got %0d expected 3", n, lat); end
      got = observe();
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL random[%0d] %s (x=%h,%h): got %h expected %h", n, names[i], a, b, got[i], exp[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_freeze_output();
    logic [5:0][31:0] got, exp;
    int lat;
    exp = expect_pair(32'h4000_0000, 32'hC0A0_0000);
    launch(32'h4000_0000, 32'hC0A0_0000);
    wait_done(lat);
    clk_en = 1'b0;
    start  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL freeze[%0d] done: got %b expected 1", c, done); end
    end
    start  = 1'b0;
    clk_en = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL freeze_release done: got %b expected 0", done); end
    got = observe();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL freeze_hold %s: got %h expected %h", names[i], got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0][31:0] got, exp;
    int lat;
    launch(32'h3F80_0000, 32'h3F80_0000);
    wait_done(lat);
    // start during the OUTPUT cycle must be ignored
    start = 1'b1; x_one = 32'h4100_0000; x_two = 32'h4100_0000;
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b done_after_output: got %b expected 0", done); end
    exp = expect_pair(32'h3FC0_0000, 32'hBFA0_0000);
    x_one = 32'h3FC0_0000; x_two = 32'hBFA0_0000;
    tick();
    start = 1'b0; x_one = 32'd0; x_two = 32'd0;
    wait_done(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL b2b latency: got %0d expected 3", lat); end
    got = observe();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b %s: got %h expected %h", names[i], got[i], exp[i]); end
    end
    tick();
  endtask

  task automatic test_start_held_toggle();
    logic [63:0] pend [$];
    logic [63:0] ops;
    logic [5:0][31:0] got, exp;
    logic exp_done;
    int k = 0;
    int jobs = 0;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      clk_en = (c % 2 == 0);
      x_one  = rand_op();
      x_two  = rand_op();
      if (clk_en && (k % 4 == 0)) pend.push_back({x_one, x_two});
      tick();
      if (clk_en) k++;
      exp_done = (k % 4 == 3);
      checks++;
      if (done !== exp_done) begin errors++; $display("FAIL held[%0d] done: got %b expected %b", c, done, exp_done); end
      if (clk_en && exp_done) begin
        checks++;
        if (pend.size() == 0) begin
          errors++; $display("FAIL held[%0d] queue: got 0 pending jobs expected 1", c);
        end else begin
          ops = pend.pop_front();
          exp = expect_pair(ops[63:32], ops[31:0]);
          got = observe();
          jobs++;
          for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL held[%0d] %s: got %h expected %h", c, names[i], got[i], exp[i]); end
          end
        end
      end
    end
    start = 1'b0;
    clk_en = 1'b1;
    checks++;
    if (jobs != 5) begin errors++; $display("FAIL held jobs: got %0d expected 5", jobs); end
    repeat (2) tick();
  endtask

  task automatic test_reset_midjob();
    logic [5:0][31:0] got, exp;
    int lat;
    launch(32'h4040_0000, 32'hBF00_0000);
    wait_done(lat);
    tick();
    launch(32'h3F80_0000, 32'h4000_0000);
    tick();               // now in COMPUTE
    rst = 1'b0;
    #1;
    got = observe();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset done: got %b expected 0", done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== 32'd0) begin errors++; $display("FAIL midreset %s: got %h expected 0", names[i], got[i]); end
    end
    #2 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL midreset_abort[%0d] done: got %b expected 0", c, done); end
    end
    exp = expect_pair(32'hC000_0000, 32'h3E00_0000);
    launch(32'hC000_0000, 32'h3E00_0000);
    wait_done(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL midreset_fresh latency: got %0d expected 3", lat); end
    got = observe();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL midreset_fresh %s: got %h expected %h", names[i], got[i], exp[i]); end
    end
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    x_one  = 32'd0;
    x_two  = 32'd0;
    #1 rst = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_freeze_output();
    test_back_to_back();
    test_start_held_toggle();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
